apb_cmd_master: RTL and testbench

- Command-stream to APB initiator. Host command words arrive over a 32-bit valid/ready stream from the USB interface, which carries register traffic only.
- The block decodes each command into single or burst APB reads and writes toward register responders such as dds_regs.
- Read data returns to the host on a 32-bit valid/ready response stream.
- It sits between the USB word FIFOs and the shared APB fabric. It is the initiator end of the interface the block register files respond to.

---
 rtl/apb_cmd_master.sv | 214 +++++++++++++++++++++
 tb/tb_apb_cmd_master.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns a 32-bit host command stream into single or burst APB reads and writes.
// Optional macro APB_PREADY_EN adds a pready input that stretches the ACCESS phase.
module apb_cmd_master #(
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned LEN_WIDTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cmd_data,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
`ifdef APB_PREADY_EN
  input  logic        pready,
`endif
  output logic        busy,
  output logic [15:0] txn_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_WDATA  = 3'd2;
  localparam logic [2:0] S_SETUP  = 3'd3;
  localparam logic [2:0] S_ACCESS = 3'd4;
  localparam logic [2:0] S_RSP    = 3'd5;

  logic [2:0]           state_q, state_d;
  logic                 wr_q, wr_d;
  logic                 fixed_q, fixed_d;
  logic [LEN_WIDTH-1:0] beats_q, beats_d;
  logic                 last_beat_q, last_beat_d;
  logic [31:0]          paddr_q, paddr_d;
  logic [31:0]          pwdata_q, pwdata_d;
  logic                 pwrite_q, pwrite_d;
  logic                 psel_q, psel_d;
  logic                 penable_q, penable_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 busy_q, busy_d;
  logic [15:0]          txn_count_q, txn_count_d;

  logic pready_s;
  logic cmd_fire_s;
  logic rsp_fire_s;
  logic complete_s;
  logic last_s;

`ifdef APB_PREADY_EN
  assign pready_s = pready;
`else
  assign pready_s = 1'b1;
`endif

  // beats_q counts remaining beats minus one, so an all-ones length never wraps early
  assign cmd_fire_s = cmd_valid & cmd_ready_q;
  assign rsp_fire_s = rsp_valid_q & rsp_ready;
  assign complete_s = (state_q == S_ACCESS) & pready_s;
  assign last_s     = (beats_q == {LEN_WIDTH{1'b0}});

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    fixed_d     = fixed_q;
    beats_d     = beats_q;
    last_beat_d = last_beat_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_data_d  = rsp_data_q;
    txn_count_d = txn_count_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_fire_s) begin
          wr_d    = cmd_data[31];
          fixed_d = cmd_data[30];
          beats_d = cmd_data[LEN_WIDTH-1:0];
          state_d = S_ADDR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ADDR: begin
        if (cmd_fire_s) begin
          paddr_d = cmd_data;
          state_d = wr_q ? S_WDATA : S_SETUP;
        end else begin
          state_d = S_ADDR;
        end
      end
      S_WDATA: begin
        if (cmd_fire_s) begin
          pwdata_d = cmd_data;
          state_d  = S_SETUP;
        end else begin
          state_d = S_WDATA;
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (complete_s) begin
          txn_count_d = txn_count_q + 16'd1;
          last_beat_d = last_s;
          if (!wr_q) begin
            rsp_data_d = prdata;
          end else begin
            rsp_data_d = rsp_data_q;
          end
          if (!last_s) begin
            beats_d = beats_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
            if (!fixed_q) begin
              paddr_d = paddr_q + 32'(ADDR_STRIDE);
            end else begin
              paddr_d = paddr_q;
            end
          end else begin
            beats_d = beats_q;
          end
          if (!wr_q) begin
            state_d = S_RSP;
          end else if (last_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WDATA;
          end
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_RSP: begin
        if (rsp_fire_s) begin
          state_d = last_beat_q ? S_IDLE : S_SETUP;
        end else begin
          state_d = S_RSP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they line up with state_q
    psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
    penable_d   = (state_d == S_ACCESS);
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_ADDR) || (state_d == S_WDATA);
    rsp_valid_d = (state_d == S_RSP);
    busy_d      = (state_d != S_IDLE);
    if (state_d == S_SETUP) begin
      pwrite_d = wr_q;
    end else begin
      pwrite_d = pwrite_q;
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      fixed_q     <= 1'b0;
      beats_q     <= {LEN_WIDTH{1'b0}};
      last_beat_q <= 1'b0;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      busy_q      <= 1'b0;
      txn_count_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      fixed_q     <= fixed_d;
      beats_q     <= beats_d;
      last_beat_q <= last_beat_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
      txn_count_q <= txn_count_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_valid = rsp_valid_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign busy      = busy_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master (LEN_WIDTH=2); APB transfers and responses are queued and compared.
module tb_apb_cmd_master;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } apb_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready = 1'b1;
  logic        busy;
  logic [15:0] txn_count;

  apb_t        exp_apb[$];
  apb_t        obs_apb[$];
  logic [31:0] exp_rsp[$];
  logic [31:0] obs_rsp[$];
  int          obs_rsp_cyc[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          setup_cnt = 0;
  logic [15:0] exp_txn = 16'h0;

  always #5 clk = ~clk;

  apb_cmd_master #(.ADDR_STRIDE(4), .LEN_WIDTH(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata),
`ifdef APB_PREADY_EN
    .pready(pready),
`endif
    .busy(busy), .txn_count(txn_count)
  );

  // Responder: data only valid during ACCESS, address-derived so beat order is visible
  function automatic logic [31:0] resp_fn(input logic [31:0] a);
    return 32'h0000_00A0 + ((a - 32'h0000_0100) >> 2);
  endfunction
  assign prdata = (psel && penable) ? resp_fn(paddr) : 32'hDEAD_BEEF;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: completed APB beats, SETUP cycles and response handshakes
  always @(negedge clk) begin
    if (reset && psel && penable && pready)
      obs_apb.push_back({pwrite, paddr, (pwrite ? pwdata : 32'h0)});
    if (reset && psel && !penable)
      setup_cnt <= setup_cnt + 1;
    if (reset && rsp_valid && rsp_ready) begin
      obs_rsp.push_back(rsp_data);
      obs_rsp_cyc.push_back(cyc);
    end
  end

  task automatic send_word(input logic [31:0] w, inout bit ok);
    int n;
    n = 0;
    cmd_data  = w;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) ok = 1'b0;
    else @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(inout bit ok, output int n);
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) ok = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({psel, penable, pwrite, cmd_ready, rsp_valid, busy, txn_count, paddr, pwdata, rsp_data} !== 118'h0) begin
      miscompares++;
      $display("FAIL reset_async: outputs=%h required all zero", {psel, penable, cmd_ready, rsp_valid, busy, txn_count});
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
    end
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, txn_count} !== {1'b1, 1'b0, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_idle: ready/busy/txn=%b/%b/%h required 1/0/0000", cmd_ready, busy, txn_count);
    end
  endtask

  task automatic test_single_write;
    bit ok;
    int n, s0;
    apb_t e, o;
    ok = 1'b1;
    s0 = setup_cnt;
    exp_apb.push_back({1'b1, 32'h0000_0010, 32'h1234_5678});
    send_word(32'h8000_0000, ok);
    send_word(32'h0000_0010, ok);
    send_word(32'h1234_5678, ok);
    wait_idle(ok, n);
    exp_txn = exp_txn + 16'd1;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL wr_timeout: got %b required 1", ok); end
    for (int i = 0; i < exp_apb.size(); i++) begin
      e = exp_apb[i];
      o = (i < obs_apb.size()) ? obs_apb[i] : '0;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL wr_apb[%0d]: got %h required %h", i, o, e); end
    end
    vectors++;
    if (obs_apb.size() != exp_apb.size()) begin miscompares++; $display("FAIL wr_apb_count: got %0d required %0d", obs_apb.size(), exp_apb.size()); end
    vectors++;
    if (setup_cnt - s0 != 1) begin miscompares++; $display("FAIL wr_setup_cycles: got %0d required 1", setup_cnt - s0); end
    vectors++;
    if ({txn_count, busy} !== {exp_txn, 1'b0}) begin miscompares++; $display("FAIL wr_txn_busy: got %h/%b required %h/0", txn_count, busy, exp_txn); end
    vectors++;
    if (obs_rsp.size() != 0) begin miscompares++; $display("FAIL wr_no_rsp: got %0d responses required 0", obs_rsp.size()); end
    exp_apb.delete(); obs_apb.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic run_read(input string name, input logic [31:0] hdr, input logic [31:0] addr, input int beats);
    bit ok;
    int n;
    apb_t e, o;
    logic [31:0] a, er, or_;
    ok = 1'b1;
    a = addr;
    for (int i = 0; i < beats; i++) begin
      exp_apb.push_back({1'b0, a, 32'h0});
      exp_rsp.push_back(resp_fn(a));
      a = a + 32'd4;
    end
    send_word(hdr, ok);
    send_word(addr, ok);
    wait_idle(ok, n);
    exp_txn = exp_txn + 16'(beats);
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL %s_timeout: got %b required 1", name, ok); end
    for (int i = 0; i < exp_apb.size(); i++) begin
      e = exp_apb[i];
      o = (i < obs_apb.size()) ? obs_apb[i] : '0;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL %s_apb[%0d]: got %h required %h", name, i, o, e); end
    end
    for (int i = 0; i < exp_rsp.size(); i++) begin
      er  = exp_rsp[i];
      or_ = (i < obs_rsp.size()) ? obs_rsp[i] : 32'hXXXX_XXXX;
      vectors++;
      if (or_ !== er) begin miscompares++; $display("FAIL %s_rsp[%0d]: got %h required %h", name, i, or_, er); end
    end
    for (int i = 1; i < obs_rsp_cyc.size(); i++) begin
      vectors++;
      if (obs_rsp_cyc[i] - obs_rsp_cyc[i-1] != 3) begin
        miscompares++;
        $display("FAIL %s_rsp_spacing[%0d]: got %0d cycles required 3", name, i, obs_rsp_cyc[i] - obs_rsp_cyc[i-1]);
      end
    end
    vectors++;
    if (obs_rsp.size() != beats || obs_apb.size() != beats) begin
      miscompares++;
      $display("FAIL %s_counts: got %0d rsp/%0d apb required %0d", name, obs_rsp.size(), obs_apb.size(), beats);
    end
    vectors++;
    if (txn_count !== exp_txn) begin miscompares++; $display("FAIL %s_txn: got %h required %h", name, txn_count, exp_txn); end
    exp_apb.delete(); obs_apb.delete(); exp_rsp.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_incr_read;
    run_read("incr_read", 32'h0000_0003, 32'h0000_0100, 4);
  endtask

  task automatic test_wrap_maxlen;
    run_read("wrap", 32'h0000_0003, 32'hFFFF_FFFC, 4);
  endtask

  task automatic test_fixed_write_gap;
    bit ok;
    int n, busy_psel;
    apb_t e, o;
    ok = 1'b1;
    busy_psel = 0;
    exp_apb.push_back({1'b1, 32'h0000_0020, 32'h0000_0001});
    exp_apb.push_back({1'b1, 32'h0000_0020, 32'h0000_0002});
    send_word(32'hC000_0001, ok);
    send_word(32'h0000_0020, ok);
    send_word(32'h0000_0001, ok);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1 && psel) busy_psel++;
    end
    vectors++;
    if (busy_psel != 0 || cmd_ready !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL fixed_gap: psel cycles=%0d ready=%b busy=%b required 0/1/1", busy_psel, cmd_ready, busy);
    end
    send_word(32'h0000_0002, ok);
    wait_idle(ok, n);
    exp_txn = exp_txn + 16'd2;
    vectors++;
    if (ok !== 1'b1) begin miscompares++; $display("FAIL fixed_timeout: got %b required 1", ok); end
    for (int i = 0; i < exp_apb.size(); i++) begin
      e = exp_apb[i];
      o = (i < obs_apb.size()) ? obs_apb[i] : '0;
      vectors++;
      if (o !== e) begin miscompares++; $display("FAIL fixed_apb[%0d]: got %h required %h", i, o, e); end
    end
    vectors++;
    if (obs_apb.size() != 2 || txn_count !== exp_txn) begin
      miscompares++;
      $display("FAIL fixed_counts: got %0d beats txn %h required 2 beats txn %h", obs_apb.size(), txn_count, exp_txn);
    end
    exp_apb.delete(); obs_apb.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_backpressure;
    bit ok;
    int n, bad;
    logic [31:0] r0;
    ok = 1'b1;
    bad = 0;
    rsp_ready = 1'b0;
    r0 = resp_fn(32'h0000_0200);
    send_word(32'h0000_0001, ok);
    send_word(32'h0000_0200, ok);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    vectors++;
    if (rsp_valid !== 1'b1 || rsp_data !== r0) begin
      miscompares++;
      $display("FAIL bp_first_rsp: valid=%b data=%h required 1/%h", rsp_valid, rsp_data, r0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== r0 || psel !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL bp_stall: got %0d unstable cycles required 0", bad); end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs_apb.size() != 1 || psel !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_before_handshake: beats=%0d psel=%b required 1/0", obs_apb.size(), psel);
    end
    @(negedge clk);
    vectors++;
    if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'h0000_0204}) begin
      miscompares++;
      $display("FAIL bp_second_setup: psel/penable/paddr=%b/%b/%h required 1/0/00000204", psel, penable, paddr);
    end
    wait_idle(ok, n);
    exp_txn = exp_txn + 16'd2;
    vectors++;
    if (ok !== 1'b1 || obs_rsp.size() != 2 || txn_count !== exp_txn) begin
      miscompares++;
      $display("FAIL bp_end: ok=%b rsp=%0d txn=%h required 1/2/%h", ok, obs_rsp.size(), txn_count, exp_txn);
    end else begin
      vectors++;
      if (obs_rsp[1] !== resp_fn(32'h0000_0204)) begin
        miscompares++;
        $display("FAIL bp_rsp1: got %h required %h", obs_rsp[1], resp_fn(32'h0000_0204));
      end
    end
    obs_apb.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
  endtask

  task automatic test_reset_mid_burst;
    bit ok;
    apb_t o;
    ok = 1'b1;
    send_word(32'h8000_0003, ok);
    send_word(32'h0000_0300, ok);
    send_word(32'h0000_00D0, ok);
    send_word(32'h0000_00D1, ok);
    @(negedge clk);
    vectors++;
    if ({psel, penable, paddr} !== {1'b1, 1'b1, 32'h0000_0304} || ok !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_access: psel/penable/paddr=%b/%b/%h required 1/1/00000304", psel, penable, paddr);
    end
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({psel, penable, busy, cmd_ready, txn_count} !== 20'h0) begin
      miscompares++;
      $display("FAIL rst_mid_async: psel/penable/busy/ready/txn=%b/%b/%b/%b/%h required all 0", psel, penable, busy, cmd_ready, txn_count);
    end
    exp_txn = 16'h0;
    vectors++;
    o = (obs_apb.size() > 0) ? obs_apb[0] : '0;
    if (o !== {1'b1, 32'h0000_0300, 32'h0000_00D0}) begin
      miscompares++;
      $display("FAIL rst_mid_beat1: got %h required %h", o, {1'b1, 32'h0000_0300, 32'h0000_00D0});
    end
    obs_apb.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cmd_ready, busy, rsp_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL rst_mid_idle: ready/busy/rsp_valid=%b/%b/%b required 1/0/0", cmd_ready, busy, rsp_valid);
    end
    run_read("post_reset", 32'h0000_0000, 32'h0000_0104, 1);
  endtask

`ifdef APB_PREADY_EN
  task automatic test_pready_wait;
    bit ok;
    int n, bad;
    logic [66:0] hold;
    ok = 1'b1;
    bad = 0;
    hold = {1'b1, 1'b1, 1'b1, 32'h0000_0500, 32'h0000_0055};
    pready = 1'b0;
    send_word(32'h8000_0000, ok);
    send_word(32'h0000_0500, ok);
    send_word(32'h0000_0055, ok);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if ({psel, penable, pwrite, paddr, pwdata} !== hold || txn_count !== exp_txn) bad++;
    end
    @(posedge clk);
    #1 pready = 1'b1;
    @(negedge clk);
    if ({psel, penable, pwrite, paddr, pwdata} !== hold) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL pready_hold: got %0d unstable cycles required 0", bad); end
    wait_idle(ok, n);
    exp_txn = exp_txn + 16'd1;
    vectors++;
    if (ok !== 1'b1 || n != 1 || txn_count !== exp_txn || obs_apb.size() != 1) begin
      miscompares++;
      $display("FAIL pready_done: ok=%b tail=%0d txn=%h beats=%0d required 1/1/%h/1", ok, n, txn_count, exp_txn, obs_apb.size());
    end
    obs_apb.delete(); obs_rsp.delete(); obs_rsp_cyc.delete();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_incr_read();
    test_fixed_write_gap();
    test_backpressure();
    test_wrap_maxlen();
    test_reset_mid_burst();
`ifdef APB_PREADY_EN
    test_pready_wait();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
